// File: rtl/button_code_encoder.sv
// Front-panel button encoder: synchronises and debounces four raw push buttons,
// then reports exactly one code (or a multi-press error) per push.
module button_code_encoder #(
    parameter int DEBOUNCE_CYCLES = 1250000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn,
    output logic [1:0] code,
    output logic       code_valid,
    output logic       multi_err,
    output logic       busy
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t           state;
    logic [3:0]       s1;
    logic [3:0]       btn_s;
    logic [3:0]       cand;
    logic [CNT_W-1:0] cnt;

    // {one_hot, index}; anything other than a single set bit is a multi-press
    function automatic logic [2:0] encode(input logic [3:0] b);
        case (b)
            4'b0001: encode = 3'b1_00;
            4'b0010: encode = 3'b1_01;
            4'b0100: encode = 3'b1_10;
            4'b1000: encode = 3'b1_11;
            default: encode = 3'b0_00;
        endcase
    endfunction

    logic [2:0] cand_enc;
    assign cand_enc = encode(cand);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1         <= 4'b0000;
            btn_s      <= 4'b0000;
            state      <= IDLE;
            cnt        <= '0;
            cand       <= 4'b0000;
            code       <= 2'b00;
            code_valid <= 1'b0;
            multi_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            s1         <= btn;
            btn_s      <= s1;
            code_valid <= 1'b0;
            multi_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (btn_s != 4'b0000) begin
                        cand  <= btn_s;
                        cnt   <= '0;
                        state <= DEBOUNCE;
                        busy  <= 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (btn_s != cand) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_MAX) begin
                        state <= HELD;
                        if (cand_enc[2]) begin
                            code       <= cand_enc[1:0];
                            code_valid <= 1'b1;
                        end else begin
                            multi_err  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HELD: begin
                    // extra buttons added while held are deliberately ignored
                    if (btn_s == 4'b0000) begin
                        cnt   <= '0;
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (btn_s != 4'b0000) begin
                        state <= HELD;
                    end else if (cnt == CNT_MAX) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
